// File: rtl/clock_divider.sv
// Programmable integer clock divider with glitch-free runtime ratio reload (load/ack handshake).
// Optional CLOCK_DIVIDER_ODD_DUTY50_EN adds a negedge phase flop for 50% duty on odd ratios.
module clock_divider #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DEF   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
  localparam logic [DIV_W:0]   ONE_W = (DIV_W+1)'(1);

  logic [DIV_W-1:0] active_div, pending_div, cnt;
  logic [DIV_W-1:0] cnt_nxt, active_nxt, last;
  logic [DIV_W:0]   half;
  logic             pending_vld, pos_q;
  logic             wrap, apply, load_ok, load_bad, phase_nxt;

  always_comb begin
    last       = active_div - ONE;
    wrap       = (cnt == last);
    apply      = en & wrap & pending_vld;
    load_ok    = div_load & (div_val >= TWO);
    load_bad   = div_load & (div_val < TWO);
    cnt_nxt    = cnt;
    active_nxt = active_div;
    if (en) begin
      cnt_nxt = wrap ? '0 : cnt + ONE;
      if (apply) active_nxt = pending_div;
    end
    // High-phase length uses the ratio in effect for the new count, so an apply edge always rises.
    half = ({1'b0, active_nxt} + ONE_W) >> 1;
`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
    if (active_nxt[0]) phase_nxt = (cnt_nxt < (active_nxt >> 1));
    else               phase_nxt = ({1'b0, cnt_nxt} < half);
`else
    phase_nxt = ({1'b0, cnt_nxt} < half);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_div  <= DEF;
      cnt         <= DEF - ONE;
      pending_div <= DEF;
      pending_vld <= 1'b0;
      pos_q       <= 1'b0;
      div_ack     <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      if (en) begin
        cnt        <= cnt_nxt;
        active_div <= active_nxt;
        pos_q      <= phase_nxt;
      end
      // A load on the apply edge wins: the old pending value is applied, the new one stays pending.
      if (load_ok) begin
        pending_div <= div_val;
        pending_vld <= 1'b1;
      end else if (apply) begin
        pending_vld <= 1'b0;
      end
      div_ack <= apply;
      div_err <= load_bad;
    end
  end

`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
  logic neg_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= pos_q;
  end

  assign clk_out = pos_q | (active_div[0] & neg_q);
`else
  assign clk_out = pos_q;
`endif

  assign tick     = en & wrap;
  assign div_busy = pending_vld;

endmodule

// File: tb/tb_clock_divider.sv
// Directed testbench for clock_divider: reset, default ratio, rejects, enable hold, reload, odd ratio, mid-run reset.
module tb_clock_divider;

  logic       clk = 1'b0;
  logic       rst_n, en, div_load;
  logic [7:0] div_val;
  logic       div_busy, div_ack, div_err, clk_out, tick;
  int         vectors = 0;
  int         miscompares = 0;

  clock_divider #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .div_load(div_load),
    .div_busy(div_busy), .div_ack(div_ack), .div_err(div_err),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++; if (clk_out !== 1'b0) begin miscompares++; $display("FAIL reset clk_out got %b want 0", clk_out); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL reset tick got %b want 0", tick); end
    vectors++; if (div_busy !== 1'b0) begin miscompares++; $display("FAIL reset div_busy got %b want 0", div_busy); end
    vectors++; if (div_ack !== 1'b0) begin miscompares++; $display("FAIL reset div_ack got %b want 0", div_ack); end
    vectors++; if (div_err !== 1'b0) begin miscompares++; $display("FAIL reset div_err got %b want 0", div_err); end
    rst_n = 1'b1;
    en    = 1'b1;
    #1;
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("FAIL reset_release tick got %b want 1", tick); end
  endtask

  task automatic test_default();
    logic [7:0] exp_clk  = 8'b11001100;
    logic [7:0] exp_tick = 8'b00010001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      vectors++; if (clk_out !== exp_clk[7-i]) begin miscompares++; $display("FAIL default clk_out[%0d] got %b want %b", i, clk_out, exp_clk[7-i]); end
      vectors++; if (tick !== exp_tick[7-i]) begin miscompares++; $display("FAIL default tick[%0d] got %b want %b", i, tick, exp_tick[7-i]); end
    end
  endtask

  task automatic test_errors();
    logic [4:0] exp_clk  = 5'b11001;
    logic [4:0] exp_tick = 5'b00010;
    logic [4:0] exp_err  = 5'b10100;
    div_load = 1'b1; div_val = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      vectors++; if (clk_out !== exp_clk[4-i]) begin miscompares++; $display("FAIL errors clk_out[%0d] got %b want %b", i, clk_out, exp_clk[4-i]); end
      vectors++; if (tick !== exp_tick[4-i]) begin miscompares++; $display("FAIL errors tick[%0d] got %b want %b", i, tick, exp_tick[4-i]); end
      vectors++; if (div_err !== exp_err[4-i]) begin miscompares++; $display("FAIL errors div_err[%0d] got %b want %b", i, div_err, exp_err[4-i]); end
      vectors++; if (div_busy !== 1'b0) begin miscompares++; $display("FAIL errors div_busy[%0d] got %b want 0", i, div_busy); end
      if (i == 0) div_load = 1'b0;
      if (i == 1) begin div_load = 1'b1; div_val = 8'd1; end
      if (i == 2) div_load = 1'b0;
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_clk  = 4'b0011;
    logic [3:0] exp_tick = 4'b0100;
    @(negedge clk); #1;
    vectors++; if (clk_out !== 1'b1) begin miscompares++; $display("FAIL enable pre clk_out got %b want 1", clk_out); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++; if (clk_out !== 1'b1) begin miscompares++; $display("FAIL enable hold clk_out[%0d] got %b want 1", i, clk_out); end
      vectors++; if (tick !== 1'b0) begin miscompares++; $display("FAIL enable hold tick[%0d] got %b want 0", i, tick); end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      vectors++; if (clk_out !== exp_clk[3-i]) begin miscompares++; $display("FAIL enable resume clk_out[%0d] got %b want %b", i, clk_out, exp_clk[3-i]); end
      vectors++; if (tick !== exp_tick[3-i]) begin miscompares++; $display("FAIL enable resume tick[%0d] got %b want %b", i, tick, exp_tick[3-i]); end
    end
  endtask

  task automatic test_load6();
    logic [11:0] exp_clk  = 12'b001110001110;
    logic [11:0] exp_tick = 12'b010000010000;
    logic [11:0] exp_busy = 12'b110000000000;
    logic [11:0] exp_ack  = 12'b001000000000;
    div_load = 1'b1; div_val = 8'd6;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      vectors++; if (clk_out !== exp_clk[11-i]) begin miscompares++; $display("FAIL load6 clk_out[%0d] got %b want %b", i, clk_out, exp_clk[11-i]); end
      vectors++; if (tick !== exp_tick[11-i]) begin miscompares++; $display("FAIL load6 tick[%0d] got %b want %b", i, tick, exp_tick[11-i]); end
      vectors++; if (div_busy !== exp_busy[11-i]) begin miscompares++; $display("FAIL load6 div_busy[%0d] got %b want %b", i, div_busy, exp_busy[11-i]); end
      vectors++; if (div_ack !== exp_ack[11-i]) begin miscompares++; $display("FAIL load6 div_ack[%0d] got %b want %b", i, div_ack, exp_ack[11-i]); end
      if (i == 0) div_load = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
`ifdef CLOCK_DIVIDER_ODD_DUTY50_EN
    logic [11:0] exp_clk  = 12'b001100011001;
`else
    logic [11:0] exp_clk  = 12'b001110011001;
`endif
    logic [11:0] exp_tick = 12'b010000100010;
    logic [11:0] exp_busy = 12'b111111100000;
    logic [11:0] exp_ack  = 12'b001000010000;
    div_load = 1'b1; div_val = 8'd5;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      vectors++; if (clk_out !== exp_clk[11-i]) begin miscompares++; $display("FAIL b2b clk_out[%0d] got %b want %b", i, clk_out, exp_clk[11-i]); end
      vectors++; if (tick !== exp_tick[11-i]) begin miscompares++; $display("FAIL b2b tick[%0d] got %b want %b", i, tick, exp_tick[11-i]); end
      vectors++; if (div_busy !== exp_busy[11-i]) begin miscompares++; $display("FAIL b2b div_busy[%0d] got %b want %b", i, div_busy, exp_busy[11-i]); end
      vectors++; if (div_ack !== exp_ack[11-i]) begin miscompares++; $display("FAIL b2b div_ack[%0d] got %b want %b", i, div_ack, exp_ack[11-i]); end
      if (i == 0) div_load = 1'b0;
      if (i == 1) begin div_load = 1'b1; div_val = 8'd4; end
      if (i == 2) div_load = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_clk  = 8'b11001100;
    logic [7:0] exp_tick = 8'b00010001;
    div_load = 1'b1; div_val = 8'd6;
    @(negedge clk); #1;
    div_load = 1'b0;
    vectors++; if (div_busy !== 1'b1) begin miscompares++; $display("FAIL rstmid pre div_busy got %b want 1", div_busy); end
    vectors++; if (clk_out !== 1'b1) begin miscompares++; $display("FAIL rstmid pre clk_out got %b want 1", clk_out); end
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (clk_out !== 1'b0) begin miscompares++; $display("FAIL rstmid async clk_out got %b want 0", clk_out); end
    vectors++; if (div_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid async div_busy got %b want 0", div_busy); end
    vectors++; if (div_ack !== 1'b0) begin miscompares++; $display("FAIL rstmid async div_ack got %b want 0", div_ack); end
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      vectors++; if (clk_out !== exp_clk[7-i]) begin miscompares++; $display("FAIL rstmid clk_out[%0d] got %b want %b", i, clk_out, exp_clk[7-i]); end
      vectors++; if (tick !== exp_tick[7-i]) begin miscompares++; $display("FAIL rstmid tick[%0d] got %b want %b", i, tick, exp_tick[7-i]); end
      vectors++; if (div_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid div_busy[%0d] got %b want 0", i, div_busy); end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = 8'd0;
    test_reset();
    test_default();
    test_errors();
    test_enable();
    test_load6();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
